// File: rtl/wb_collect.sv
// Writeback collector: grants one ex-pipe result per cycle and registers it onto the PRF write and ROB completion ports.
// Define NCPU_WB_RR_ARB_EN for round-robin arbitration; otherwise the lowest valid channel wins.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module wb_collect #(
  parameter int CONFIG_AW             = 32,
  parameter int CONFIG_DW             = 32,
  parameter int CONFIG_P_ROB_DEPTH    = 4,
  parameter int CONFIG_P_COMMIT_WIDTH = 2,
  parameter int NUM_CH                = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [NUM_CH-1:0]                       ch_valid,
  output logic [NUM_CH-1:0]                       ch_ready,
  input  logic [NUM_CH*CONFIG_P_ROB_DEPTH-1:0]    ch_rob_id,
  input  logic [NUM_CH*CONFIG_P_COMMIT_WIDTH-1:0] ch_rob_bank,
  input  logic [NUM_CH-1:0]                       ch_prf_we,
  input  logic [NUM_CH*`NCPU_PRF_AW-1:0]          ch_prf_waddr,
  input  logic [NUM_CH*CONFIG_DW-1:0]             ch_prf_wdata,
  input  logic [NUM_CH-1:0]                       ch_fls,
  input  logic [NUM_CH-1:0]                       ch_exc,
  input  logic [NUM_CH*CONFIG_AW-1:0]             ch_opera,
  input  logic [NUM_CH*CONFIG_DW-1:0]             ch_operb,
  output logic                                    rob_wb_valid,
  output logic [CONFIG_P_ROB_DEPTH-1:0]           rob_wb_id,
  output logic [CONFIG_P_COMMIT_WIDTH-1:0]        rob_wb_bank,
  output logic                                    rob_wb_fls,
  output logic                                    rob_wb_exc,
  output logic [CONFIG_AW-1:0]                    rob_wb_opera,
  output logic [CONFIG_DW-1:0]                    rob_wb_operb,
  output logic                                    prf_WE,
  output logic [`NCPU_PRF_AW-1:0]                 prf_WADDR,
  output logic [CONFIG_DW-1:0]                    prf_WDATA
);

  localparam int PA = `NCPU_PRF_AW;
  localparam int RW = CONFIG_P_ROB_DEPTH;
  localparam int BW = CONFIG_P_COMMIT_WIDTH;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] gnt;
  logic [IW-1:0]     sel;
  logic              hs;

`ifdef NCPU_WB_RR_ARB_EN
  logic [IW-1:0] rr_ptr;

  // Scan from the farthest offset down so the nearest valid channel at/after rr_ptr wins.
  always_comb begin
    int unsigned c;
    gnt = '0;
    sel = '0;
    c   = 0;
    if (!flush) begin
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        c = int'(rr_ptr) + (NUM_CH - 1 - j);
        if (c >= NUM_CH) c = c - NUM_CH;
        if (ch_valid[c]) begin
          gnt    = '0;
          gnt[c] = 1'b1;
          sel    = IW'(c);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (sel == IW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
    end
  end
`else
  always_comb begin
    gnt = '0;
    sel = '0;
    if (!flush) begin
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (ch_valid[NUM_CH - 1 - j]) begin
          gnt                 = '0;
          gnt[NUM_CH - 1 - j] = 1'b1;
          sel                 = IW'(NUM_CH - 1 - j);
        end
      end
    end
  end
`endif

  assign hs       = |gnt;
  assign ch_ready = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_wb_valid <= 1'b0;
      rob_wb_fls   <= 1'b0;
      rob_wb_exc   <= 1'b0;
      prf_WE       <= 1'b0;
      rob_wb_id    <= '0;
      rob_wb_bank  <= '0;
      rob_wb_opera <= '0;
      rob_wb_operb <= '0;
      prf_WADDR    <= '0;
      prf_WDATA    <= '0;
    end else begin
      rob_wb_valid <= hs;
      rob_wb_fls   <= hs & ch_fls[sel];
      rob_wb_exc   <= hs & ch_exc[sel];
      prf_WE       <= hs & ch_prf_we[sel];
      if (hs) begin
        rob_wb_id    <= ch_rob_id[int'(sel)*RW +: RW];
        rob_wb_bank  <= ch_rob_bank[int'(sel)*BW +: BW];
        rob_wb_opera <= ch_opera[int'(sel)*CONFIG_AW +: CONFIG_AW];
        rob_wb_operb <= ch_operb[int'(sel)*CONFIG_DW +: CONFIG_DW];
        prf_WADDR    <= ch_prf_waddr[int'(sel)*PA +: PA];
        prf_WDATA    <= ch_prf_wdata[int'(sel)*CONFIG_DW +: CONFIG_DW];
      end
    end
  end

endmodule

// File: tb/tb_wb_collect.sv
// Scoreboard bench for wb_collect: expected outputs are queued per cycle and compared after the clock edge.
module tb_wb_collect;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int BW = 2;
`ifdef NCPU_PRF_AW
  localparam int PA = `NCPU_PRF_AW;
`else
  localparam int PA = 6;
`endif

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] id;
    logic [BW-1:0] bank;
    logic          fls;
    logic          exc;
    logic [AW-1:0] opera;
    logic [DW-1:0] operb;
    logic          we;
    logic [PA-1:0] waddr;
    logic [DW-1:0] wdata;
  } rec_t;

  logic clk = 1'b0;
  logic rst, flush;
  logic [N-1:0]    ch_valid, ch_ready, ch_prf_we, ch_fls, ch_exc;
  logic [N*RW-1:0] ch_rob_id;
  logic [N*BW-1:0] ch_rob_bank;
  logic [N*PA-1:0] ch_prf_waddr;
  logic [N*DW-1:0] ch_prf_wdata, ch_operb;
  logic [N*AW-1:0] ch_opera;
  logic            rob_wb_valid, rob_wb_fls, rob_wb_exc, prf_WE;
  logic [RW-1:0]   rob_wb_id;
  logic [BW-1:0]   rob_wb_bank;
  logic [AW-1:0]   rob_wb_opera;
  logic [DW-1:0]   rob_wb_operb, prf_WDATA;
  logic [PA-1:0]   prf_WADDR;

  int checks = 0;
  int errors = 0;
  rec_t sb[$];
  rec_t last_data;
  int   m_rr;
  rec_t obs, exp_r;
  logic [N-1:0] rdy, eg;

  always #5 clk = ~clk;

  wb_collect #(
    .CONFIG_AW(AW), .CONFIG_DW(DW), .CONFIG_P_ROB_DEPTH(RW),
    .CONFIG_P_COMMIT_WIDTH(BW), .NUM_CH(N)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_rob_id(ch_rob_id), .ch_rob_bank(ch_rob_bank),
    .ch_prf_we(ch_prf_we), .ch_prf_waddr(ch_prf_waddr), .ch_prf_wdata(ch_prf_wdata),
    .ch_fls(ch_fls), .ch_exc(ch_exc), .ch_opera(ch_opera), .ch_operb(ch_operb),
    .rob_wb_valid(rob_wb_valid), .rob_wb_id(rob_wb_id), .rob_wb_bank(rob_wb_bank),
    .rob_wb_fls(rob_wb_fls), .rob_wb_exc(rob_wb_exc),
    .rob_wb_opera(rob_wb_opera), .rob_wb_operb(rob_wb_operb),
    .prf_WE(prf_WE), .prf_WADDR(prf_WADDR), .prf_WDATA(prf_WDATA)
  );

  function automatic rec_t sample();
    rec_t r;
    r.valid = rob_wb_valid; r.id = rob_wb_id; r.bank = rob_wb_bank;
    r.fls = rob_wb_fls; r.exc = rob_wb_exc; r.opera = rob_wb_opera;
    r.operb = rob_wb_operb; r.we = prf_WE; r.waddr = prf_WADDR; r.wdata = prf_WDATA;
    return r;
  endfunction

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] v, input logic fl, input int rr);
    logic [N-1:0] g;
    logic found;
    g = '0;
    found = 1'b0;
    if (!fl) begin
      for (int o = 0; o < N; o++) begin
        int c;
        c = (rr + o) % N;
        if (v[c] && !found) begin
          g[c] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic set_ch(input int i, input logic v, input logic [RW-1:0] id, input logic [BW-1:0] bank,
                        input logic we, input logic [PA-1:0] wa, input logic [DW-1:0] wd,
                        input logic fl, input logic ex, input logic [AW-1:0] oa, input logic [DW-1:0] ob);
    ch_valid[i] = v;
    ch_rob_id[i*RW +: RW] = id;
    ch_rob_bank[i*BW +: BW] = bank;
    ch_prf_we[i] = we;
    ch_prf_waddr[i*PA +: PA] = wa;
    ch_prf_wdata[i*DW +: DW] = wd;
    ch_fls[i] = fl;
    ch_exc[i] = ex;
    ch_opera[i*AW +: AW] = oa;
    ch_operb[i*DW +: DW] = ob;
  endtask

  // Advances one cycle: samples ch_ready mid-cycle, queues the expected registered outputs.
  task automatic step(output logic [N-1:0] ready_obs, output logic [N-1:0] gnt_exp);
    rec_t e;
    @(negedge clk);
    ready_obs = ch_ready;
    gnt_exp = model_gnt(ch_valid, flush, m_rr);
    e = last_data;
    e.valid = 1'b0; e.fls = 1'b0; e.exc = 1'b0; e.we = 1'b0;
    if (rst) begin
      e = '0;
      last_data = '0;
      m_rr = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (gnt_exp[k]) begin
          e.valid = 1'b1;
          e.id    = ch_rob_id[k*RW +: RW];
          e.bank  = ch_rob_bank[k*BW +: BW];
          e.fls   = ch_fls[k];
          e.exc   = ch_exc[k];
          e.opera = ch_opera[k*AW +: AW];
          e.operb = ch_operb[k*DW +: DW];
          e.we    = ch_prf_we[k];
          e.waddr = ch_prf_waddr[k*PA +: PA];
          e.wdata = ch_prf_wdata[k*DW +: DW];
          last_data = e;
`ifdef NCPU_WB_RR_ARB_EN
          m_rr = (k + 1) % N;
`endif
        end
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(rdy, eg);
      obs = sample(); exp_r = sb.pop_front(); checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL reset_out got %h exp %h", obs, exp_r); end
    end
    checks++;
    if (rdy !== '0) begin errors++; $display("FAIL reset_ready got %b exp %b", rdy, 2'b00); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_ch(0, 1'b1, 4'd5, 2'd1, 1'b1, 6'd9, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h1234);
    step(rdy, eg);
    set_ch(0, 1'b0, 4'd0, 2'd0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    obs = sample(); exp_r = sb.pop_front(); checks++;
    if (obs !== exp_r) begin errors++; $display("FAIL single_out got %h exp %h", obs, exp_r); end
    checks++;
    if (rob_wb_id !== 4'd5 || prf_WDATA !== 32'hDEADBEEF || prf_WADDR !== 6'd9 || prf_WE !== 1'b1)
      begin errors++; $display("FAIL single_fields got id=%0d wa=%0d wd=%h we=%b exp id=5 wa=9 wd=deadbeef we=1", rob_wb_id, prf_WADDR, prf_WDATA, prf_WE); end
    checks++;
    if (rdy !== eg) begin errors++; $display("FAIL single_ready got %b exp %b", rdy, eg); end
    step(rdy, eg);
    obs = sample(); exp_r = sb.pop_front(); checks++;
    if (obs !== exp_r || rob_wb_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %h exp %h", obs, exp_r); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want [4];
`ifdef NCPU_WB_RR_ARB_EN
    want = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    want = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst = 1'b1; step(rdy, eg); void'(sb.pop_front()); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_ch(0, 1'b1, RW'(c), 2'd0, 1'b1, PA'(c), DW'(c * 16), 1'b0, 1'b0, AW'(c), 32'h0);
      set_ch(1, 1'b1, RW'(c + 8), 2'd3, 1'b1, PA'(c + 32), DW'(c * 16 + 1), 1'b0, 1'b0, AW'(c + 100), 32'h1);
      step(rdy, eg);
      checks++;
      if (rdy !== want[c]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", c, rdy, want[c]); end
      obs = sample(); exp_r = sb.pop_front(); checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL rr_out%0d got %h exp %h", c, obs, exp_r); end
    end
    set_ch(0, 1'b0, 4'd0, 2'd0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_ch(1, 1'b0, 4'd0, 2'd0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_flush();
    // Advance the pointer to 1 first (RR build) so a flush that disturbed it would show.
    set_ch(0, 1'b1, 4'd2, 2'd0, 1'b0, 6'd3, 32'h33, 1'b0, 1'b0, 32'h7, 32'h0);
    step(rdy, eg); void'(sb.pop_front());
    set_ch(0, 1'b1, 4'd4, 2'd0, 1'b0, 6'd3, 32'h33, 1'b0, 1'b0, 32'h7, 32'h0);
    set_ch(1, 1'b1, 4'd6, 2'd2, 1'b1, 6'd11, 32'h55, 1'b1, 1'b0, 32'h8, 32'h9);
    flush = 1'b1;
    step(rdy, eg);
    flush = 1'b0;
    checks++;
    if (rdy !== '0) begin errors++; $display("FAIL flush_ready got %b exp %b", rdy, 2'b00); end
    obs = sample(); exp_r = sb.pop_front(); checks++;
    if (obs !== exp_r || rob_wb_valid !== 1'b0 || rob_wb_fls !== 1'b0) begin errors++; $display("FAIL flush_out got %h exp %h", obs, exp_r); end
    step(rdy, eg);
    checks++;
    if (rdy !== eg) begin errors++; $display("FAIL flush_rr_hold got %b exp %b", rdy, eg); end
    obs = sample(); exp_r = sb.pop_front(); checks++;
    if (obs !== exp_r) begin errors++; $display("FAIL flush_after got %h exp %h", obs, exp_r); end
    set_ch(0, 1'b0, 4'd0, 2'd0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_ch(1, 1'b0, 4'd0, 2'd0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_exc();
    set_ch(1, 1'b1, 4'd12, 2'd2, 1'b0, 6'd17, 32'hCAFEF00D, 1'b0, 1'b1, 32'h1F, 32'hABCD);
    step(rdy, eg);
    set_ch(1, 1'b0, 4'd0, 2'd0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    obs = sample(); exp_r = sb.pop_front(); checks++;
    if (obs !== exp_r) begin errors++; $display("FAIL exc_out got %h exp %h", obs, exp_r); end
    checks++;
    if (rob_wb_exc !== 1'b1 || rob_wb_opera !== 32'h1F || prf_WE !== 1'b0)
      begin errors++; $display("FAIL exc_fields got exc=%b opera=%h we=%b exp exc=1 opera=1f we=0", rob_wb_exc, rob_wb_opera, prf_WE); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++)
        set_ch(i, 1'($urandom_range(0, 1)), RW'($urandom), BW'($urandom), 1'($urandom), PA'($urandom),
               DW'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
      flush = ($urandom_range(0, 7) == 0);
      step(rdy, eg);
      checks++;
      if (rdy !== eg) begin errors++; $display("FAIL b2b_ready%0d got %b exp %b", c, rdy, eg); end
      obs = sample(); exp_r = sb.pop_front(); checks++;
      if (obs !== exp_r) begin errors++; $display("FAIL b2b_out%0d got %h exp %h", c, obs, exp_r); end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_ch(0, 1'b1, 4'd9, 2'd1, 1'b1, 6'd21, 32'h11112222, 1'b1, 1'b1, 32'h5, 32'h6);
    rst = 1'b1;
    step(rdy, eg);
    rst = 1'b0;
    set_ch(0, 1'b0, 4'd0, 2'd0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    obs = sample(); exp_r = sb.pop_front(); checks++;
    if (obs !== exp_r || rob_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got %h exp %h", obs, exp_r); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    ch_valid = '0; ch_prf_we = '0; ch_fls = '0; ch_exc = '0;
    ch_rob_id = '0; ch_rob_bank = '0; ch_prf_waddr = '0; ch_prf_wdata = '0;
    ch_opera = '0; ch_operb = '0;
    last_data = '0; m_rr = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_exc();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
